// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared widths and types for the I/D cache memory arbiter
package cache_mem_arbiter_pkg;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GAP} arb_state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: line-wide pmem port between a cache and the cacheline adaptor
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = cache_mem_arbiter_pkg::ADDR_W,
  parameter int LINE_W = cache_mem_arbiter_pkg::LINE_W
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;
  modport master (output address, read, write, wdata, input rdata, resp);
  modport slave (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline adaptor between the I-cache and D-cache, one line transaction at a time
module cache_mem_arbiter #(
  parameter int LINE_W      = cache_mem_arbiter_pkg::LINE_W,
  parameter int ADDR_W      = cache_mem_arbiter_pkg::ADDR_W,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave  i_pmem,
  cache_mem_arbiter_if.slave  d_pmem,
  cache_mem_arbiter_if.master pmem
);
  import cache_mem_arbiter_pkg::*;

  arb_state_t        state_q, state_d;
  side_t             last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              req_i, req_d, pick_d, granted;

  assign req_i   = i_pmem.read | i_pmem.write;
  assign req_d   = d_pmem.read | d_pmem.write;
  assign pick_d  = req_d & (~req_i | ~ROUND_ROBIN | (last_q == SIDE_I));
  assign granted = state_q inside {GRANT_I, GRANT_D};

  // A winner asserting both read and write is treated as a write
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: if (req_i | req_d) begin
        state_d = pick_d ? GRANT_D : GRANT_I;
        addr_d  = pick_d ? d_pmem.address : i_pmem.address;
        wdata_d = pick_d ? d_pmem.wdata : i_pmem.wdata;
        wr_d    = pick_d ? d_pmem.write : i_pmem.write;
      end
      GRANT_I, GRANT_D: if (pmem.resp) begin
        state_d = GAP;
        last_d  = (state_q == GRANT_D) ? SIDE_D : SIDE_I;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign pmem.read    = granted & ~wr_q;
  assign pmem.write   = granted & wr_q;
  assign pmem.address = addr_q;
  assign pmem.wdata   = wdata_q;
  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;
  assign i_pmem.resp  = (state_q == GRANT_I) & pmem.resp;
  assign d_pmem.resp  = (state_q == GRANT_D) & pmem.resp;

  a_i_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(i_pmem.read && i_pmem.write));
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_pmem.read && d_pmem.write));
  a_resp_in_grant:  assert property (@(posedge clk) disable iff (rst) pmem.resp |-> granted);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: checks a fixed-priority and a round-robin arbiter against a transaction-level model
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              ir, iw, dr, dw;
  logic [31:0]       ia, da;
  logic [255:0]      iwd, dwd, mrd;
  logic [1:0]        mresp;
  logic [31:0]       o_addr [2];
  logic [255:0]      o_wdata [2], o_irdata [2], o_drdata [2];
  logic              o_read [2], o_write [2], o_iresp [2], o_dresp [2];

  cache_mem_arbiter_if ic0(), dc0(), mm0(), ic1(), dc1(), mm1();

  assign ic0.address = ia;  assign ic0.read = ir;  assign ic0.write = iw;  assign ic0.wdata = iwd;
  assign dc0.address = da;  assign dc0.read = dr;  assign dc0.write = dw;  assign dc0.wdata = dwd;
  assign ic1.address = ia;  assign ic1.read = ir;  assign ic1.write = iw;  assign ic1.wdata = iwd;
  assign dc1.address = da;  assign dc1.read = dr;  assign dc1.write = dw;  assign dc1.wdata = dwd;
  assign mm0.rdata = mrd;   assign mm0.resp = mresp[0];
  assign mm1.rdata = mrd;   assign mm1.resp = mresp[1];

  assign o_addr[0] = mm0.address;  assign o_wdata[0] = mm0.wdata;
  assign o_read[0] = mm0.read;     assign o_write[0] = mm0.write;
  assign o_irdata[0] = ic0.rdata;  assign o_drdata[0] = dc0.rdata;
  assign o_iresp[0] = ic0.resp;    assign o_dresp[0] = dc0.resp;
  assign o_addr[1] = mm1.address;  assign o_wdata[1] = mm1.wdata;
  assign o_read[1] = mm1.read;     assign o_write[1] = mm1.write;
  assign o_irdata[1] = ic1.rdata;  assign o_drdata[1] = dc1.rdata;
  assign o_iresp[1] = ic1.resp;    assign o_dresp[1] = dc1.resp;

  cache_mem_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (.clk(clk), .rst(rst), .i_pmem(ic0), .d_pmem(dc0), .pmem(mm0));
  cache_mem_arbiter #(.ROUND_ROBIN(1'b1)) dut1 (.clk(clk), .rst(rst), .i_pmem(ic1), .d_pmem(dc1), .pmem(mm1));

  int total = 0;
  int bad = 0;

  // Model per arbiter: owner 0=none 1=I 2=D, a pending gap cycle, last side served, latched transaction
  int          own [2];
  bit          gap [2];
  int          last [2];
  int          bcnt [2];
  logic [31:0] laddr [2];
  logic [255:0] lwd [2];
  bit          lwr [2];

  typedef struct {
    bit ir, dr, dw;
    logic [31:0] ia, da;
    bit rsp, e_rd, e_wr;
    logic [31:0] e_addr;
    bit e_ir, e_dr;
  } vec_t;
  vec_t tbl [13];

  function automatic vec_t mk(bit ir_, bit dr_, bit dw_, logic [31:0] ia_, logic [31:0] da_, bit rsp_,
                              bit erd, bit ewr, logic [31:0] ea, bit eir, bit edr);
    vec_t v;
    v.ir = ir_; v.dr = dr_; v.dw = dw_; v.ia = ia_; v.da = da_; v.rsp = rsp_;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; gap[k] = 1'b0; last[k] = 1; bcnt[k] = 0;
      laddr[k] = '0; lwd[k] = '0; lwr[k] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit ireq, dreq;
    int w;
    ireq = ir | iw;
    dreq = dr | dw;
    for (int k = 0; k < 2; k++) begin
      if (own[k] != 0) begin
        if (mresp[k]) begin last[k] = own[k]; own[k] = 0; gap[k] = 1'b1; end
        else bcnt[k]++;
      end else if (gap[k]) gap[k] = 1'b0;
      else if (ireq || dreq) begin
        w = !ireq ? 2 : !dreq ? 1 : (k == 0 ? 2 : 3 - last[k]);
        own[k] = w; bcnt[k] = 1;
        laddr[k] = (w == 2) ? da : ia;
        lwd[k]   = (w == 2) ? dwd : iwd;
        lwr[k]   = (w == 2) ? dw : iw;
      end
    end
  endfunction

  task automatic check_all();
    bit busy;
    for (int k = 0; k < 2; k++) begin
      busy = own[k] != 0;
      chk($sformatf("read%0d", k), 256'(o_read[k]), 256'(busy && !lwr[k]));
      chk($sformatf("write%0d", k), 256'(o_write[k]), 256'(busy && lwr[k]));
      chk($sformatf("addr%0d", k), 256'(o_addr[k]), 256'(laddr[k]));
      chk($sformatf("wdata%0d", k), o_wdata[k], lwd[k]);
      chk($sformatf("iresp%0d", k), 256'(o_iresp[k]), 256'(own[k] == 1 && mresp[k]));
      chk($sformatf("dresp%0d", k), 256'(o_dresp[k]), 256'(own[k] == 2 && mresp[k]));
      chk($sformatf("irdata%0d", k), o_irdata[k], mrd);
      chk($sformatf("drdata%0d", k), o_drdata[k], mrd);
    end
  endtask

  task automatic drive(input bit ir_, iw_, input logic [31:0] ia_, input bit dr_, dw_, input logic [31:0] da_);
    ir = ir_; iw = iw_; ia = ia_; dr = dr_; dw = dw_; da = da_;
    iwd = rnd256(); dwd = rnd256();
  endtask

  // One clock: drive at negedge, adaptor answers after lat grant cycles (lat<0: randomly), check, advance model
  task automatic cyc(input bit ir_, iw_, input logic [31:0] ia_, input bit dr_, dw_, input logic [31:0] da_, input int lat);
    @(negedge clk);
    drive(ir_, iw_, ia_, dr_, dw_, da_);
    if (lat < 0) mrd = rnd256();
    for (int k = 0; k < 2; k++)
      mresp[k] = (own[k] != 0) && (lat < 0 ? ($urandom_range(0, 3) == 0) : (bcnt[k] >= lat));
    #1;
    check_all();
    model_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int q0 [$];
    int q1 [$];
    int first_rd, rsp_at, ip, dp, phase, gaplow;
    bit sawhi;
    int exp0 [4];
    int exp1 [4];
    exp0 = '{2, 2, 2, 2};
    exp1 = '{1, 2, 1, 2};
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   32'h320, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,   32'h320, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,   32'h320, 1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0);

    rst = 1'b1;
    ir = 1'b0; iw = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0;
    iwd = '0; dwd = '0; mrd = '0; mresp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // Reset while the D-cache fill is granted
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1000);
    @(negedge clk);
    rst = 1'b1;
    dr = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_read%0d", k), 256'(o_read[k]), 256'(0));
      chk($sformatf("rst_dresp%0d", k), 256'(o_dresp[k]), 256'(0));
      chk($sformatf("rst_addr%0d", k), 256'(o_addr[k]), 256'(0));
    end
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Conflict with fixed priority, then address change while granted
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      drive(tbl[r].ir, 1'b0, tbl[r].ia, tbl[r].dr, tbl[r].dw, tbl[r].da);
      mresp = {2{tbl[r].rsp}};
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("t%0d_read%0d", r, k), 256'(o_read[k]), 256'(tbl[r].e_rd));
        chk($sformatf("t%0d_write%0d", r, k), 256'(o_write[k]), 256'(tbl[r].e_wr));
        chk($sformatf("t%0d_addr%0d", r, k), 256'(o_addr[k]), 256'(tbl[r].e_addr));
        chk($sformatf("t%0d_iresp%0d", r, k), 256'(o_iresp[k]), 256'(tbl[r].e_ir));
        chk($sformatf("t%0d_dresp%0d", r, k), 256'(o_dresp[k]), 256'(tbl[r].e_dr));
      end
      model_step();
    end

    // Both sides held with last grant D: serve order per arbiter
    for (int c = 0; c < 40 && (q0.size() < 4 || q1.size() < 4); c++) begin
      cyc(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 3);
      if (o_iresp[0]) q0.push_back(1);
      if (o_dresp[0]) q0.push_back(2);
      if (o_iresp[1]) q1.push_back(1);
      if (o_dresp[1]) q1.push_back(2);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fixed_order%0d", i), 256'(i < q0.size() ? q0[i] : 0), 256'(exp0[i]));
      chk($sformatf("rr_order%0d", i), 256'(i < q1.size() ? q1[i] : 0), 256'(exp1[i]));
    end
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3);

    // Lone I-cache read answered after 12 grant cycles
    mrd = {32{8'hA5}};
    first_rd = -1; rsp_at = -1; ip = 0; dp = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(ip == 0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 12);
      if (o_read[0] && first_rd < 0) first_rd = c;
      if (o_iresp[0]) begin
        ip++;
        rsp_at = c;
        chk("lone_rdata", o_irdata[0], {32{8'hA5}});
      end
      if (o_dresp[0] || o_dresp[1]) dp++;
    end
    chk("lone_first_read", 256'(first_rd), 256'(1));
    chk("lone_resp_cycle", 256'(rsp_at), 256'(12));
    chk("lone_i_pulses", 256'(ip), 256'(1));
    chk("lone_d_pulses", 256'(dp), 256'(0));

    // D write-back then fill held through the gap
    phase = 0; gaplow = 0; sawhi = 1'b0;
    for (int c = 0; c < 60 && phase < 2; c++) begin
      cyc(1'b0, 1'b0, 32'h0, phase == 1, phase == 0, phase == 0 ? 32'h400 : 32'h800, 3);
      if (phase == 1 && !sawhi && !o_read[0] && !o_write[0]) gaplow++;
      if (phase == 1 && !sawhi && o_read[0]) begin
        sawhi = 1'b1;
        chk("b2b_addr2", 256'(o_addr[0]), 256'(32'h800));
      end
      if (o_dresp[0]) phase++;
    end
    chk("b2b_d_pulses", 256'(phase), 256'(2));
    chk("b2b_idle_gap", 256'(gaplow), 256'(2));

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int oi, od;
      oi = $urandom_range(0, 7);
      od = $urandom_range(0, 7);
      cyc(oi inside {[4:6]}, oi == 7, $urandom & 32'hFFFF_FFE0,
          od inside {[3:5]}, od >= 6, $urandom & 32'hFFFF_FFE0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
